data_mem_responder: RTL

Data-memory responder for the multi-cycle MIPS core: the memory-side end of the `mem_read_flag` / `mem_write_flag` interface driven by the control unit during its MEM state. It accepts one word read or write request, inserts a configurable number of wait states, and then commits the access. It signals completion with a one-cycle `ready` pulse and flags misaligned or conflicting requests.

---
 rtl/data_mem_responder_pkg.sv | 20 ++
 rtl/data_mem_responder_dmem_array.sv | 34 +++
 rtl/data_mem_responder.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/data_mem_responder_pkg.sv
// Shared constants and types for the data-memory responder.
package data_mem_responder_pkg;

    localparam int unsigned MEM_DEPTH   = 256;
    localparam int unsigned MEM_LATENCY = 2;
    localparam int unsigned MEM_DATA_W  = 32;
    localparam int unsigned MEM_ADDR_W  = 32;
    localparam int unsigned CNT_W       = 4;

    typedef enum logic {
        OP_READ  = 1'b0,
        OP_WRITE = 1'b1
    } mem_op_t;

    // A word access must sit on a 4-byte boundary.
    function automatic logic is_misaligned(input logic [1:0] byte_sel);
        return byte_sel != 2'b00;
    endfunction

endpackage

// File: rtl/data_mem_responder_dmem_array.sv
// Single-port synchronous word RAM with a registered, enable-held read port.
module dmem_array #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned DEPTH  = 256,
    localparam int unsigned IDX_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic              re,
    input  logic [IDX_W-1:0]  idx,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] dout
);

    logic [DATA_W-1:0] mem [DEPTH];

    // Storage write; contents are deliberately not reset.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[idx] <= din;
        end
    end

    // Read register holds its value until the next enabled read.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dout <= '0;
        end else if (re) begin
            dout <= mem[idx];
        end
    end

endmodule

// File: rtl/data_mem_responder.sv
// Memory-side responder: edge-accepts one word access, waits LATENCY cycles,
// commits it and pulses ready (with err for misaligned/conflicting requests).
module data_mem_responder
    import data_mem_responder_pkg::*;
#(
    parameter int unsigned DATA_W  = MEM_DATA_W,
    parameter int unsigned DEPTH   = MEM_DEPTH,
    parameter int unsigned LATENCY = MEM_LATENCY
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  mem_read,
    input  logic                  mem_write,
    input  logic [MEM_ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0]     wdata,
    output logic [DATA_W-1:0]     rdata,
    output logic                  ready,
    output logic                  err
);

    localparam int unsigned IDX_W = $clog2(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t            state;
    state_t            state_next;
    logic              req;
    logic              req_q;
    logic              accept;
    logic              bad_now;
    mem_op_t           op_now;
    logic [IDX_W-1:0]  idx_now;
    logic [IDX_W-1:0]  idx_q;
    logic [DATA_W-1:0] wdata_q;
    mem_op_t           op_q;
    logic              bad_q;
    logic [CNT_W-1:0]  cnt;
    logic              commit;
    logic [IDX_W-1:0]  sel_idx;
    logic [DATA_W-1:0] sel_din;
    mem_op_t           sel_op;
    logic              sel_bad;
    logic              arr_we;
    logic              arr_re;
    logic              unused_addr_bits;

    assign req     = mem_read | mem_write;
    assign accept  = (state == S_IDLE) & req & ~req_q;
    assign bad_now = is_misaligned(addr[1:0]) | (mem_read & mem_write);
    assign op_now  = mem_write ? OP_WRITE : OP_READ;
    assign idx_now = addr[IDX_W+1:2];
    assign unused_addr_bits = ^addr[MEM_ADDR_W-1:IDX_W+2];

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic; zero latency goes straight to the response.
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    state_next = (LATENCY == 0) ? S_RESP : S_BUSY;
                end
            end
            S_BUSY: begin
                if (cnt == CNT_W'(1)) begin
                    state_next = S_RESP;
                end
            end
            S_RESP:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // Commit controls; a commit straight from IDLE uses the live request.
    always_comb begin
        commit  = (state_next == S_RESP) && (state != S_RESP);
        sel_idx = idx_q;
        sel_din = wdata_q;
        sel_op  = op_q;
        sel_bad = bad_q;
        if (state == S_IDLE) begin
            sel_idx = idx_now;
            sel_din = wdata;
            sel_op  = op_now;
            sel_bad = bad_now;
        end
        arr_we = commit & ~rst & ~sel_bad & (sel_op == OP_WRITE);
        arr_re = commit & ~rst & ~sel_bad & (sel_op == OP_READ);
    end

    // Request edge detect, latched request and wait-state counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            req_q   <= 1'b0;
            idx_q   <= '0;
            wdata_q <= '0;
            op_q    <= OP_READ;
            bad_q   <= 1'b0;
            cnt     <= '0;
        end else begin
            req_q <= req;
            if (accept) begin
                idx_q   <= idx_now;
                wdata_q <= wdata;
                op_q    <= op_now;
                bad_q   <= bad_now;
                cnt     <= CNT_W'(LATENCY);
            end else if (state == S_BUSY) begin
                cnt <= cnt - CNT_W'(1);
            end
        end
    end

    // Completion and error pulses, registered off the commit edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ready <= 1'b0;
            err   <= 1'b0;
        end else begin
            ready <= commit;
            err   <= commit & sel_bad;
        end
    end

    dmem_array #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_array (
        .clk  (clk),
        .rst  (rst),
        .we   (arr_we),
        .re   (arr_re),
        .idx  (sel_idx),
        .din  (sel_din),
        .dout (rdata)
    );

endmodule
